// File: rtl/polar_inst_fetch.sv
// polar_inst_fetch: walks the PC over the instruction memory and registers each
// returned instruction into a valid/ready stage feeding the decode datapath.
module polar_inst_fetch #(
    parameter int ADDR_W   = 8,
    parameter int INST_W   = 12,
    parameter int INST_NUM = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [INST_W-1:0] mem_inst,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

    // Final address kept at ADDR_W bits; pc stops here, so INST_NUM=2^ADDR_W never wraps.
    localparam logic [ADDR_W-1:0] PC_END = ADDR_W'(INST_NUM - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic              load, hs;

    assign load     = state == RUN && (!inst_valid || inst_ready);
    assign hs       = state == LAST && inst_valid && inst_ready;
    assign mem_addr = pc;
    assign mem_en   = state == RUN;
    assign busy     = state != IDLE;

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        if (flush) begin
            state_nx = IDLE;
            pc_nx    = '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state_nx = RUN;
                    pc_nx    = '0;
                end
                RUN: if (load) begin
                    state_nx = pc == PC_END ? LAST : RUN;
                    pc_nx    = pc == PC_END ? pc : pc + 1'b1;
                end
                LAST: state_nx = hs ? IDLE : LAST;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            inst       <= !flush && load ? mem_inst : inst;
            inst_valid <= flush ? 1'b0 : load ? 1'b1 : hs ? 1'b0 : inst_valid;
            done       <= !flush && hs;
        end
    end
endmodule

// File: doc/polar_inst_fetch.md
# polar_inst_fetch

Instruction fetch sequencer for the polar-code decoder. On a `start` pulse it walks the program counter from address 0 to `INST_NUM-1`, driving the instruction memory's address and enable ports. It registers each returned 12-bit instruction into a valid/ready output stage that feeds the decode datapath. When the last instruction is consumed, it pulses `done` and returns to idle.

## Interface
- `ADDR_W`, 8: instruction memory address width.
- `INST_W`, 12: instruction width.
- `INST_NUM`, 64: number of instructions per program; legal range is 1 to 2^`ADDR_W`.

- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  single-cycle request to run the program; sampled only in IDLE.
- `flush`  input  1  synchronous abort; highest priority after reset.
- `mem_addr`  output  `ADDR_W`  instruction memory address, equal to `pc`.
- `mem_en`  output  1  instruction memory enable; high only in RUN.
- `mem_inst`  input  `INST_W`  instruction memory read data, combinational from `mem_addr`/`mem_en`.
- `inst`  output  `INST_W`  registered instruction to the datapath.
- `inst_valid`  output  1  `inst` is valid.
- `inst_ready`  input  1  datapath accepts `inst`; a handshake occurs when `inst_valid` and `inst_ready` are both high.
- `busy`  output  1  state is not IDLE.
- `done`  output  1  one-cycle pulse after the final instruction handshake.

## Operation
- State machine states: IDLE, RUN, LAST.
- IDLE:
  - `start`=1 sets `pc`=0 and moves to RUN.
  - `mem_en`=0.
  - `inst_valid` is 0.
- RUN:
  - `mem_en`=1, `mem_addr`=`pc`.
  - Load condition: `load = !inst_valid || inst_ready`.
  - On load: `inst<=mem_inst`, `inst_valid<=1`.
  - On load with `pc` < `INST_NUM-1`: `pc<=pc+1`.
  - On load with `pc` == `INST_NUM-1`: `pc` holds and the state moves to LAST.
  - With no load, `pc` and `inst` hold; `inst` must not change while `inst_valid && !inst_ready`.
- LAST:
  - `mem_en`=0.
  - The final instruction waits in the output register.
  - On handshake: `inst_valid<=0`, `done<=1` for one cycle, move to IDLE.
- `pc` is `ADDR_W` bits wide. It is compared against `INST_NUM-1` and never increments past it, so no wrap occurs even when `INST_NUM`=2^`ADDR_W`.
- `start` outside IDLE is ignored, including `start` together with `flush`.
- `start` in the cycle `done` is high is accepted, because the state is already IDLE.
- `flush`: next edge sets state=IDLE, `inst_valid`=0, `pc`=0; no `done` is produced. `flush` wins over a simultaneous handshake or load.
- `INST_NUM`=1: RUN lasts one cycle, then LAST.

## Timing
- Reset values: state IDLE, `pc`=0, `mem_addr`=0, `mem_en`=0, `inst`=0, `inst_valid`=0, `busy`=0, `done`=0.
- Reset asserted mid-run forces these values immediately (asynchronously).
- `start` sampled at edge of cycle N:
  - Cycle N+1: RUN, `mem_addr`=0.
  - Cycle N+2: `inst_valid`=1 with instruction 0.
- With `inst_ready` held high: one instruction per cycle. Instruction k is valid in cycle N+2+k.
- The final handshake occurs in cycle N+1+`INST_NUM`; `done`=1 in cycle N+2+`INST_NUM`.
- `busy` is registered state: high from cycle N+1 until `done` is asserted; low in the cycle `done` is high.
- `done` is registered; it is never high for two consecutive cycles.
- Backpressure: while `inst_valid`=1 and `inst_ready`=0, `inst`, `pc` and `mem_addr` are frozen. Throughput resumes in the cycle `inst_ready` returns.

## Test plan
- Reset: drive `rst_n`=0 asynchronously mid-cycle. Required: all outputs at their reset values immediately; `start` is ignored while `rst_n`=0.
- Full run: `INST_NUM`=4, memory contents 0x0A1, 0x0B2, 0x0C3, 0x0D4, `inst_ready`=1, `start` at cycle 0. Required: valid words in cycles 2, 3, 4, 5 in that order; `done`=1 only in cycle 6; `busy` high in cycles 1–5.
- Backpressure: as the full run, but `inst_ready`=0 in cycles 3–5. Required: `inst` holds 0x0B2 for cycles 3–6; `mem_addr` holds 2; `done` appears in cycle 9; no word is lost or duplicated.
- Ignored start: pulse `start` in cycles 0 and 3. Required: a single program pass; `pc` is unaffected by the second pulse.
- Flush mid-run: pulse `flush` in cycle 3, together with `inst_ready`=1. Required: cycle 4 IDLE, `inst_valid`=0, `busy`=0, `done` never high.
- Back-to-back: assert `start` in the `done` cycle. Required: the second pass starts with `mem_addr`=0 in the next cycle and has identical output timing; `INST_NUM`=1 completes with `done` in cycle 3.
